// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT buffer read controller.
// Optional feature macro: BUFFER_READ_BITREV_EN (adds the bit-reversal pass helper).
package fft_pkg;

  localparam int FFT_POINTS      = 256;
  localparam int BEATS_PER_STAGE = 32;
  localparam int NUM_STAGES      = 8;
  localparam int ADDR_W          = 8;
  localparam int BEAT_W          = 5;
  localparam int STAGE_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef BUFFER_READ_BITREV_EN
  // Mirror an address end-for-end (bit 0 <-> bit 7 and so on).
  function automatic logic [ADDR_W-1:0] bitrev8(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction
`endif

endpackage

// File: rtl/bfly_addr.sv
// Radix-2 butterfly address pair: for butterfly b in a stage with half-span
// h = 128 >> stage, top = (b / h) * 2h + (b mod h) and bottom = top + h.
// Because h is a power of two this is just a zero inserted into b at bit
// position log2(h), so no divider is needed.
module bfly_addr
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [6:0]         b,
  output logic [ADDR_W-1:0]  top,
  output logic [ADDR_W-1:0]  bottom
);

  logic [ADDR_W-1:0] h;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] b_ext;

  // Split b around the half-span bit and open a gap there for the partner.
  always_comb begin
    h      = ADDR_W'(FFT_POINTS / 2) >> stage;
    mask   = h - 8'd1;
    b_ext  = {1'b0, b};
    top    = ((b_ext & ~mask) << 1) | (b_ext & mask);
    bottom = top + h;
  end

endmodule

// File: rtl/buffer_read_ctrl.sv
// Read-side address generator for a 256-point in-place radix-2 FFT buffer.
// Each READ beat presents four butterflies (eight addresses); 32 beats make a
// stage, 8 stages make a frame. Define BUFFER_READ_BITREV_EN to append a
// bit-reversed read-out pass after stage 7.
module buffer_read_ctrl
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ADDR_W-1:0]  rd_pt0,
  output logic [ADDR_W-1:0]  rd_pt1,
  output logic [ADDR_W-1:0]  rd_pt2,
  output logic [ADDR_W-1:0]  rd_pt3,
  output logic [ADDR_W-1:0]  rd_pt4,
  output logic [ADDR_W-1:0]  rd_pt5,
  output logic [ADDR_W-1:0]  rd_pt6,
  output logic [ADDR_W-1:0]  rd_pt7,
  output logic               bank,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               frame_done
);

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 bank_q, bank_d;
  logic                 pend_q, pend_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    rd_pt_q [8];
  logic [ADDR_W-1:0]    rd_pt_d [8];
  logic [ADDR_W-1:0]    top [4];
  logic [ADDR_W-1:0]    bot [4];
  logic                 last_beat;
`ifdef BUFFER_READ_BITREV_EN
  logic                 bitrev_q, bitrev_d;
`endif

  // Address pairs are computed for the beat/stage that will be shown next
  // cycle, so the registered addresses line up with rd_valid.
  for (genvar m = 0; m < 4; m++) begin : g_bfly
    bfly_addr u_bfly (
      .stage  (stage_d),
      .b      ({beat_d, 2'(m)}),
      .top    (top[m]),
      .bottom (bot[m])
    );
  end

  // Next-state logic: beat/stage sequencing, bank toggling, start capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    beat_d    = beat_q;
    stage_d   = stage_q;
    bank_d    = bank_q;
    pend_d    = pend_q;
`ifdef BUFFER_READ_BITREV_EN
    bitrev_d  = bitrev_q;
`endif
    last_beat = (beat_q == BEAT_W'(BEATS_PER_STAGE - 1));

    unique case (state_q)
      IDLE: begin
        // A start seen during DONE is held in pend_q and launched from here.
        if (start || pend_q) begin
          state_d = READ;
          beat_d  = '0;
          stage_d = '0;
          pend_d  = 1'b0;
`ifdef BUFFER_READ_BITREV_EN
          bitrev_d = 1'b0;
`endif
        end
      end
      READ: begin
        if (rd_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
`ifdef BUFFER_READ_BITREV_EN
            if (bitrev_q) begin
              state_d = DONE;
            end else if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
              bitrev_d = 1'b1;
              bank_d   = ~bank_q;
            end else begin
              stage_d = stage_q + 1'b1;
              bank_d  = ~bank_q;
            end
`else
            if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
              state_d = DONE;
            end else begin
              stage_d = stage_q + 1'b1;
              bank_d  = ~bank_q;
            end
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pend_d  = start;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output can be registered.
  always_comb begin
    rd_valid_d = (state_d == READ);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    for (int j = 0; j < 8; j++) rd_pt_d[j] = '0;
    if (state_d == READ) begin
`ifdef BUFFER_READ_BITREV_EN
      if (bitrev_d) begin
        for (int j = 0; j < 8; j++) rd_pt_d[j] = bitrev8({beat_d, 3'(j)});
      end else begin
`else
      begin
`endif
        for (int m = 0; m < 4; m++) begin
          rd_pt_d[2*m]   = top[m];
          rd_pt_d[2*m+1] = bot[m];
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      stage_q    <= '0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BUFFER_READ_BITREV_EN
      bitrev_q   <= 1'b0;
`endif
      // NOTE: the address bank is eight plain flops, not a memory, so it is
      // cleared with the rest of the state.
      for (int j = 0; j < 8; j++) rd_pt_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      stage_q    <= stage_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BUFFER_READ_BITREV_EN
      bitrev_q   <= bitrev_d;
`endif
      for (int j = 0; j < 8; j++) rd_pt_q[j] <= rd_pt_d[j];
    end
  end

  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign bank       = bank_q;
  assign stage      = stage_q;
  assign rd_pt0     = rd_pt_q[0];
  assign rd_pt1     = rd_pt_q[1];
  assign rd_pt2     = rd_pt_q[2];
  assign rd_pt3     = rd_pt_q[3];
  assign rd_pt4     = rd_pt_q[4];
  assign rd_pt5     = rd_pt_q[5];
  assign rd_pt6     = rd_pt_q[6];
  assign rd_pt7     = rd_pt_q[7];

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Bench for buffer_read_ctrl. The reference model walks a frame as a flat
// list of beats n = 0..NB-1 and derives stage and addresses arithmetically.
module tb_buffer_read_ctrl;

`ifdef BUFFER_READ_BITREV_EN
  localparam int NB = 288;
`else
  localparam int NB = 256;
`endif

  logic       clk = 1'b0;
  logic       reset, start, rd_ready;
  logic       rd_valid, bank, busy, frame_done;
  logic [7:0] rd_pt0, rd_pt1, rd_pt2, rd_pt3, rd_pt4, rd_pt5, rd_pt6, rd_pt7;
  logic [2:0] stage;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   toggles = 0;
  int   start_cyc = 0;

  // Reference model state: phase 0 idle, 1 reading, 2 done pulse.
  int   m_phase = 0;
  int   m_n     = 0;
  logic m_bank  = 1'b0;
  logic m_pend  = 1'b0;

  buffer_read_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_pt0     (rd_pt0),
    .rd_pt1     (rd_pt1),
    .rd_pt2     (rd_pt2),
    .rd_pt3     (rd_pt3),
    .rd_pt4     (rd_pt4),
    .rd_pt5     (rd_pt5),
    .rd_pt6     (rd_pt6),
    .rd_pt7     (rd_pt7),
    .bank       (bank),
    .stage      (stage),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dut_addrs();
    return {rd_pt0, rd_pt1, rd_pt2, rd_pt3, rd_pt4, rd_pt5, rd_pt6, rd_pt7};
  endfunction

  // Expected eight addresses for flat beat index n, packed pt0 in the MSBs.
  function automatic logic [63:0] exp_addrs(input int n);
    logic [7:0] p [8];
    int s, k, h, b, v;
    if (n >= 256) begin
      for (int j = 0; j < 8; j++) begin
        v = 8 * (n - 256) + j;
        for (int i = 0; i < 8; i++) p[j][i] = v[7-i];
      end
    end else begin
      s = n / 32;
      k = n % 32;
      h = 128 >> s;
      for (int m = 0; m < 4; m++) begin
        b = 4 * k + m;
        p[2*m]   = 8'((b / h) * 2 * h + b % h);
        p[2*m+1] = 8'((b / h) * 2 * h + b % h + h);
      end
    end
    return {p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7]};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_n = 0; m_bank = 1'b0; m_pend = 1'b0;
    end else begin
      case (m_phase)
        0: if (start || m_pend) begin m_phase = 1; m_n = 0; m_pend = 1'b0; end
        1: if (rd_ready) begin
             if (m_n == NB - 1) m_phase = 2;
             else begin
               if (m_n % 32 == 31) m_bank = ~m_bank;
               m_n++;
             end
           end
        default: begin m_phase = 0; m_pend = start; end
      endcase
    end
  endtask

  task automatic compare();
    check("valid", rd_valid, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("frame_done", frame_done, m_phase == 2);
    check("bank", bank, m_bank);
    if (m_phase == 1) begin
      check("stage", stage, (m_n >= 256) ? 7 : m_n / 32);
      check("addr", dut_addrs(), exp_addrs(m_n));
      if (m_n == 0)   check("first_beat", dut_addrs(), 64'h00_80_01_81_02_82_03_83);
      if (m_n == 224) check("s7_b0", dut_addrs(), 64'h00_01_02_03_04_05_06_07);
      if (m_n == 101) check("s3_b5", dut_addrs(),
                            {8'd36, 8'd52, 8'd37, 8'd53, 8'd38, 8'd54, 8'd39, 8'd55});
`ifdef BUFFER_READ_BITREV_EN
      if (m_n == 256) check("bitrev_b0", dut_addrs(), 64'h00_80_40_C0_20_A0_60_E0);
`endif
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    logic prev_bank;
    prev_bank = bank;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    if (bank !== prev_bank) toggles++;
    compare();
  endtask

  task automatic start_frame();
    start = 1'b1;
    cycle();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Run until frame_done with rd_ready high pct% of cycles; -1 on timeout.
  task automatic wait_done(input int pct, input int limit, output int done_c);
    done_c = -1;
    for (int i = 0; i < limit && done_c < 0; i++) begin
      rd_ready = ($urandom_range(0, 99) < pct);
      cycle();
      if (frame_done) done_c = cyc;
    end
    if (done_c < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int done_c;
    int seen;
    logic [63:0] snap;
    logic [2:0]  snap_stage;

    reset = 1'b1; start = 1'b0; rd_ready = 1'b0;
    cycle();
    cycle();
    check("rst_outs", {rd_valid, busy, frame_done, bank, stage}, 0);
    check("rst_addr", dut_addrs(), 0);
    reset = 1'b0;
    cycle();

    // Continuous ready, with stray starts while busy.
    rd_ready = 1'b1;
    toggles  = 0;
    start_frame();
    done_c = -1;
    for (int i = 0; i < NB + 20 && done_c < 0; i++) begin
      start = (i == 40 || i == 100);
      cycle();
      if (frame_done) done_c = cyc;
    end
    start = 1'b0;
    // frame_done is high in the cycle ending at edge done_c+1; start was high
    // in the cycle ending at edge start_cyc.
    check("done_latency", done_c + 1 - start_cyc, NB + 1);
    check("bank_toggles", toggles, NB / 32 - 1);
    cycle();
    check("idle_after", busy, 0);
    cycle();

    // Five-cycle stall mid-stage.
    rd_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 40; i++) cycle();
    rd_ready   = 1'b0;
    snap       = dut_addrs();
    snap_stage = stage;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_addr", dut_addrs(), snap);
      check("stall_stage", stage, snap_stage);
    end
    done_c = -1;
    rd_ready = 1'b1;
    for (int i = 0; i < NB + 20 && done_c < 0; i++) begin
      cycle();
      if (frame_done) done_c = cyc;
    end
    check("stall_latency", done_c + 1 - start_cyc, NB + 1 + 5);
    cycle();

    // Random back-pressure frames; the second is restarted during frame_done.
    start_frame();
    wait_done(70, 3000, done_c);
    cycle();
    start_frame();
    wait_done(60, 3000, done_c);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("done_start_idle", {busy, rd_valid}, 0);
    cycle();
    check("done_start_read", rd_valid, 1);
    wait_done(85, 3000, done_c);
    cycle();

    // Reset at stage 4 beat 10 abandons the frame.
    start_frame();
    for (int i = 0; i < 3000 && !(m_phase == 1 && m_n == 138); i++) begin
      rd_ready = ($urandom_range(0, 99) < 80);
      cycle();
    end
    check("reach_s4_b10", m_n, 138);
    reset = 1'b1;
    cycle();
    check("rst_mid_outs", {rd_valid, busy, frame_done, bank, stage}, 0);
    check("rst_mid_addr", dut_addrs(), 0);
    reset    = 1'b0;
    rd_ready = 1'b1;
    seen     = 0;
    for (int i = 0; i < NB + 20; i++) begin
      cycle();
      if (frame_done) seen = 1;
    end
    check("no_done_after_rst", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
